logic_sweep_ctrl: RTL

LOGIC_SWEEP_CTRL -- requirements
Module: logic_sweep_ctrl

---
 rtl/logic_sweep_ctrl_if.sv | 26 ++
 rtl/logic_sweep_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/logic_sweep_ctrl_if.sv
// Bundle between the sweep controller and its environment: start request,
// the a/b/c vector drive, the x response and the sweep status outputs.
interface logic_sweep_ctrl_if;
  logic       start;
  logic       a_o;
  logic       b_o;
  logic       c_o;
  logic       x_i;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] err_cnt;
  logic [2:0] vec_idx;

  // master: the sweep controller itself
  modport master (
    input  start, x_i,
    output a_o, b_o, c_o, busy, done, fail, err_cnt, vec_idx
  );

  // slave: the block under control plus whoever requests sweeps
  modport slave (
    output start, x_i,
    input  a_o, b_o, c_o, busy, done, fail, err_cnt, vec_idx
  );
endinterface

// File: rtl/logic_sweep_ctrl.sv
// Exhaustive 3-input sweep of an x = ~a | (b & c) block, counting mismatches.
// Define LOGIC_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module logic_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input logic                clk,
  input logic                rst_n,
  logic_sweep_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

`ifdef LOGIC_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_settle, w_settle_nxt;
  logic [2:0] r_vec, w_vec_nxt;
  logic [3:0] r_err, w_err_nxt;
  logic       w_expect;
  logic       w_mismatch;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // The vector register drives the block directly, so the reference is built from it.
  assign w_expect   = ~r_vec[2] | (r_vec[1] & r_vec[0]);
  assign w_mismatch = (bus.x_i != w_expect);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_settle <= 4'd0;
      r_vec    <= 3'd0;
      r_err    <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
      r_vec    <= w_vec_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_vec_nxt    = r_vec;
    w_err_nxt    = r_err;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = S_APPLY;
          w_vec_nxt   = 3'd0;
          w_err_nxt   = 4'd0;
        end
      end
      S_APPLY: begin
        w_state_nxt  = S_SETTLE;
        w_settle_nxt = SETTLE_LOAD;
      end
      S_SETTLE: begin
        if (r_settle == 4'd0) w_state_nxt = S_SAMPLE;
        else                  w_settle_nxt = r_settle - 4'd1;
      end
      S_SAMPLE: begin
        if (w_mismatch) w_err_nxt = sat_inc(r_err);
        // Stop-on-fail freezes vec_idx on the failing vector for diagnosis.
        if ((STOP_ON_FAIL && w_mismatch) || (r_vec == 3'd7)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_vec_nxt   = r_vec + 3'd1;
          w_state_nxt = S_APPLY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.a_o     = r_vec[2];
  assign bus.b_o     = r_vec[1];
  assign bus.c_o     = r_vec[0];
  assign bus.vec_idx = r_vec;
  assign bus.err_cnt = r_err;
  assign bus.fail    = (r_err != 4'd0);
  assign bus.busy    = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign bus.done    = (r_state == S_DONE);

endmodule
